tropang_rom_loader: RTL and testbench

- Download-side stage that sits between the HPS ioctl byte stream and the SDRAM controller's port1/port2 write interfaces.
- Captures ioctl bytes into a small FIFO and drives toggle req/ack write handshakes with the right address and byte-lane mapping:
  - port1 (CPU/sound ROMs) receives every ROM byte;
  - port2 (sprite ROMs) receives only the 32-bit-merged sprite region.
- Also latches the 8 DIP bytes, applies ioctl_wait back-pressure, and raises rom_loaded once the download has fully drained to SDRAM.

---
 rtl/tropang_pkg.sv | 22 ++
 rtl/tropang_dl_fifo.sv | 48 ++++
 rtl/tropang_rom_loader.sv | 131 +++++++++++++
 tb/tb_tropang_rom_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tropang_pkg.sv
// tropang_pkg: shared ROM map, ioctl indices, download FIFO entry and loader FSM states
package tropang_pkg;

    localparam logic [24:0] ROM_MAIN_BASE = 25'h00000;
    localparam logic [24:0] ROM_SND_BASE  = 25'h08000;
    localparam logic [24:0] ROM_GFX1_BASE = 25'h0A000;
    localparam logic [24:0] ROM_SP_BASE   = 25'h10000;
    localparam logic [24:0] ROM_SP_END    = 25'h1BFFF;
    localparam logic [24:0] ROM_PROM_BASE = 25'h1C000;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_DIP = 8'd254;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        sp;
    } dl_entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} dl_state_t;

endpackage

// File: rtl/tropang_dl_fifo.sv
// tropang_dl_fifo: synchronous FIFO of download entries
// Ports: clk/reset (async, active-high), push/din write, pop/dout read (dout shows head),
//        count/full/empty status. Push when full and pop when empty are ignored.
module tropang_dl_fifo
    import tropang_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  dl_entry_t                din,
    output dl_entry_t                dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    dl_entry_t      mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic           do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/tropang_rom_loader.sv
// tropang_rom_loader: ioctl download to SDRAM port1/port2 toggle-handshake writer
// Ports: clk/reset (async, active-high); ioctl_* download stream in, ioctl_wait back-pressure out;
//        port1_* every ROM byte, port2_* sprite region only (req toggles, done when ack==req);
//        dip_sw latched DIP bytes; rom_loaded sticky completion; busy FIFO/handshake activity.
module tropang_rom_loader
    import tropang_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] SP_BASE    = ROM_SP_BASE,
    parameter logic [24:0] SP_END     = ROM_SP_END,
    parameter logic [7:0]  ROM_INDEX  = IDX_ROM,
    parameter logic [7:0]  DIP_INDEX  = IDX_DIP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port1_we,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port2_we,
    output logic [63:0] dip_sw,
    output logic        rom_loaded,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    dl_state_t      state, state_nx;
    dl_entry_t      ent, head;
    logic [CW-1:0]  count;
    logic           full, empty;
    logic           wr_d, dl_d, armed, overflow, sp_r;
    logic           rise, push, dip_wr, load, issue, pop;
    logic [23:0]    off;

    assign rise       = ioctl_wr && !wr_d && ioctl_download;
    assign push       = rise && ioctl_index == ROM_INDEX;
    assign dip_wr     = rise && ioctl_index == DIP_INDEX && ioctl_addr[24:3] == '0;
    assign ent        = '{addr: ioctl_addr, data: ioctl_dout,
                          sp: ioctl_addr >= SP_BASE && ioctl_addr <= SP_END};
    assign ioctl_wait = count >= CW'(FIFO_DEPTH - 1);
    assign busy       = !empty || state != ST_IDLE;
    assign port1_we   = ioctl_download || busy;
    assign port2_we   = ioctl_download || busy;
    // Sprite offset only needs 24 bits; the low bits of a 25-bit subtraction are identical.
    assign off        = head.addr[23:0] - SP_BASE[23:0];

    tropang_dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ent),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        load     = state == ST_IDLE && !empty;
        issue    = state == ST_ISSUE;
        pop      = state == ST_WAIT && port1_ack == port1_req && (!sp_r || port2_ack == port2_req);
        state_nx = load ? ST_ISSUE : issue ? ST_WAIT : pop ? ST_IDLE : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_d       <= 1'b0;
            dl_d       <= 1'b0;
            armed      <= 1'b0;
            overflow   <= 1'b0;
            sp_r       <= 1'b0;
            rom_loaded <= 1'b0;
            dip_sw     <= '0;
            port1_req  <= 1'b0;
            port1_a    <= '0;
            port1_ds   <= '0;
            port1_d    <= '0;
            port2_req  <= 1'b0;
            port2_a    <= '0;
            port2_ds   <= '0;
            port2_d    <= '0;
        end else begin
            wr_d <= ioctl_wr;
            dl_d <= ioctl_download;
            if (load) begin
                sp_r     <= head.sp;
                port1_a  <= head.addr[23:1];
                port1_ds <= {head.addr[0], ~head.addr[0]};
                port1_d  <= {2{head.data}};
                // Sprite bytes are merged into 32-bit words: off[15] picks the word half,
                // off[14] picks the byte lane.
                port2_a  <= {off[23:16], off[13:0], off[15]};
                port2_ds <= {off[14], ~off[14]};
                port2_d  <= {2{head.data}};
            end
            if (issue) begin
                port1_req <= ~port1_req;
                if (sp_r) port2_req <= ~port2_req;
            end
            if (push && full) overflow <= 1'b1;
            if (dip_wr) dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            // Completion is armed by the end of a ROM download and fires once everything has drained.
            if (dl_d && !ioctl_download && ioctl_index == ROM_INDEX) armed <= 1'b1;
            else if (armed && empty && state == ST_IDLE) begin
                armed      <= 1'b0;
                rom_loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tropang_rom_loader.sv
// tb_tropang_rom_loader: directed bench with an SDRAM-side responder checking writes against a byte-level model
module tb_tropang_rom_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0, ioctl_index = '0;
    logic        ioctl_wait;
    logic        port1_req, port1_ack = 1'b0, port1_we;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req, port2_ack = 1'b0, port2_we;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic [63:0] dip_sw;
    logic        rom_loaded, busy;

    always #5 clk = ~clk;

    tropang_rom_loader dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
        .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
        .port1_ds(port1_ds), .port1_d(port1_d), .port1_we(port1_we),
        .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
        .port2_ds(port2_ds), .port2_d(port2_d), .port2_we(port2_we),
        .dip_sw(dip_sw), .rom_loaded(rom_loaded), .busy(busy)
    );

    int          checks = 0, errors = 0;
    logic [40:0] q1[$], q2[$];
    logic [40:0] cur1 = '0, cur2 = '0;
    int          cnt1 = -1, cnt2 = -1, dly1 = 2, dly2 = 2;
    logic        prev1 = 1'b0, prev2 = 1'b0, saw_wait = 1'b0;
    logic [63:0] exp_dip = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Port1 sees the byte address as a 16-bit word address with an odd/even lane.
    function automatic logic [40:0] p1map(input logic [24:0] a, input logic [7:0] d);
        int unsigned w  = int'(a) / 2;
        logic [1:0]  ds = (int'(a) % 2 == 1) ? 2'b10 : 2'b01;
        return {23'(w), ds, d, d};
    endfunction

    // Port2 sees the sprite offset packed as 32-bit words split over two 16-bit halves.
    function automatic logic [40:0] p2map(input logic [24:0] a, input logic [7:0] d);
        int unsigned off = (int'(a) - 32'h10000) % 32'h2000000;
        int unsigned w   = ((off / 65536) % 256) * 32768 + (off % 16384) * 2 + (off / 32768) % 2;
        logic [1:0]  ds  = ((off / 16384) % 2 == 1) ? 2'b10 : 2'b01;
        return {23'(w), ds, d, d};
    endfunction

    task automatic send(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        int t = 0;
        while (ioctl_wait && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout actual=ioctl_wait_stuck required=released");
        end
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        if (ioctl_download && idx == 8'd0) begin
            q1.push_back(p1map(a, d));
            if (a >= 25'h10000 && a <= 25'h1BFFF) q2.push_back(p2map(a, d));
        end
        if (ioctl_download && idx == 8'd254 && a < 25'd8) exp_dip[int'(a)*8 +: 8] = d;
        @(negedge clk);
        ioctl_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || cnt1 >= 0 || cnt2 >= 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", 64'(t < 1000), 64'd1);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
    endtask

    // SDRAM-side responder: checks each write at its request toggle, then acks after a delay.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            port1_ack = 1'b0;
            port2_ack = 1'b0;
            prev1 = 1'b0;
            prev2 = 1'b0;
            cnt1 = -1;
            cnt2 = -1;
        end else begin
            if (ioctl_wait) saw_wait = 1'b1;
            if (port1_req !== prev1) begin
                prev1 = port1_req;
                cur1 = {port1_a, port1_ds, port1_d};
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL p1_unexpected_write actual=%h required=none", cur1);
                end else chk("p1_write", 64'(cur1), 64'(q1.pop_front()));
                chk("p1_we", 64'(port1_we), 64'd1);
                cnt1 = dly1;
            end else if (cnt1 > 0) cnt1--;
            if (cnt1 == 0) begin
                chk("p1_hold", 64'({port1_a, port1_ds, port1_d}), 64'(cur1));
                port1_ack = port1_req;
                cnt1 = -1;
            end
            if (port2_req !== prev2) begin
                prev2 = port2_req;
                cur2 = {port2_a, port2_ds, port2_d};
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL p2_unexpected_write actual=%h required=none", cur2);
                end else chk("p2_write", 64'(cur2), 64'(q2.pop_front()));
                chk("p2_we", 64'(port2_we), 64'd1);
                cnt2 = dly2;
            end else if (cnt2 > 0) cnt2--;
            if (cnt2 == 0) begin
                chk("p2_hold", 64'({port2_a, port2_ds, port2_d}), 64'(cur2));
                port2_ack = port2_req;
                cnt2 = -1;
            end
        end
    end

    initial begin
        int t;
        logic [24:0] burst [6];
        burst = '{25'h0FFFF, 25'h10000, 25'h1BFFF, 25'h1C000, 25'h00100, 25'h00101};
        repeat (3) @(negedge clk);
        chk("rst_port1_req", 64'(port1_req), 64'd0);
        chk("rst_port2_req", 64'(port2_req), 64'd0);
        chk("rst_port1_a", 64'(port1_a), 64'd0);
        chk("rst_dip_sw", dip_sw, 64'd0);
        chk("rst_rom_loaded", 64'(rom_loaded), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wait", 64'(ioctl_wait), 64'd0);
        chk("rst_we", 64'(port1_we), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        ioctl_download = 1'b1;
        ioctl_index = 8'd0;
        @(negedge clk);

        send(8'd0, 25'h00003, 8'h5A);
        wait_idle();
        chk("t1_port1_word", 64'(cur1), 64'({23'h000001, 2'b10, 16'h5A5A}));
        chk("t1_port2_req", 64'(port2_req), 64'd0);

        dly1 = 1;
        dly2 = 10;
        send(8'd0, 25'h14001, 8'hC3);
        t = 0;
        while (!(cnt1 < 0 && cnt2 >= 0 && port1_ack == port1_req) && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("t2_busy_until_p2_ack", 64'(busy), 64'd1);
        chk("t2_p2_pending", 64'(cnt2 > 0), 64'd1);
        wait_idle();
        chk("t2_port2_word", 64'(cur2), 64'({23'h000002, 2'b10, 16'hC3C3}));
        chk("t2_port1_word", 64'(cur1), 64'({23'h00A000, 2'b10, 16'hC3C3}));

        dly1 = 8;
        dly2 = 8;
        saw_wait = 1'b0;
        for (int i = 0; i < 6; i++) send(8'd0, burst[i], 8'h30 + 8'(i));
        wait_idle();
        chk("t3_wait_seen", 64'(saw_wait), 64'd1);
        chk("t3_no_overflow", 64'(dut.overflow), 64'd0);

        send(8'd3, 25'h00010, 8'hEE);
        repeat (6) @(negedge clk);
        wait_idle();

        send(8'd0, 25'h00200, 8'hA0);
        send(8'd0, 25'h00201, 8'hA1);
        send(8'd0, 25'h00202, 8'hA2);
        ioctl_download = 1'b0;
        t = 0;
        while ((q1.size() > 0 || cnt1 >= 0) && t < 500) begin
            chk("t5_not_loaded_yet", 64'(rom_loaded), 64'd0);
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("t5_rom_loaded", 64'(rom_loaded), 64'd1);
        wait_idle();
        chk("t5_we_low", 64'(port1_we), 64'd0);

        ioctl_index = 8'd254;
        ioctl_download = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) send(8'd254, 25'(i), 8'h11 * 8'(i + 1));
        send(8'd254, 25'd8, 8'hFF);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_dip_model", dip_sw, exp_dip);
        chk("t4_dip_literal", dip_sw, 64'h8877665544332211);
        chk("t4_loaded_sticky", 64'(rom_loaded), 64'd1);
        send(8'd0, 25'h00300, 8'h77);
        repeat (4) @(negedge clk);
        wait_idle();

        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        @(negedge clk);
        chk("t6_loaded_after_rise", 64'(rom_loaded), 64'd1);
        dly1 = 20;
        send(8'd0, 25'h00005, 8'h99);
        t = 0;
        while (cnt1 < 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_req", 64'(port1_req), 64'd0);
        chk("t6_rst_a", 64'(port1_a), 64'd0);
        chk("t6_rst_ds", 64'(port1_ds), 64'd0);
        chk("t6_rst_d", 64'(port1_d), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_loaded", 64'(rom_loaded), 64'd0);
        q1.delete();
        q2.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dly1 = 2;
        @(negedge clk);
        send(8'd0, 25'h00005, 8'h99);
        wait_idle();
        chk("t6_fresh_word", 64'(cur1), 64'({23'h000002, 2'b10, 16'h9999}));
        chk("final_no_overflow", 64'(dut.overflow), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
